// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, phase codes and default timing for the HD44780 nibble bus driver
package lcd_pkg;

  localparam int T_AS_DEFAULT = 2;
  localparam int T_PW_DEFAULT = 12;
  localparam int T_H_DEFAULT  = 2;
  localparam int T_EL_DEFAULT = 13;

  // DB7 carries the busy flag on the high-nibble read
  localparam int BF_BIT = 3;

  typedef enum logic [3:0] {
    IDLE,
    W_SETUP,
    W_EHI,
    W_HOLD,
    W_GAP,
    R_SETUP,
    R_EHI,
    R_HOLD,
    R_GAP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EHI,
    PH_HOLD,
    PH_GAP
  } phase_t;

  function automatic phase_t phase_of(input state_t s);
    case (s)
      W_EHI, R_EHI:   phase_of = PH_EHI;
      W_HOLD, R_HOLD: phase_of = PH_HOLD;
      W_GAP, R_GAP:   phase_of = PH_GAP;
      default:        phase_of = PH_SETUP;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_bus_driver_if.sv
// rtl/lcd_nibble_bus_driver_if.sv - sequencer handshake and LCD pin bundle
interface lcd_nibble_bus_driver_if;

  logic       sendCommand;
  logic [3:0] command;
  logic       commandRs;
  logic       readBusy;
  logic       commandDone;
  logic       busy;
  logic       timeoutError;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE;
  logic [3:0] LCD_DATA_IN;

  modport master (
    output sendCommand, command, commandRs, readBusy, LCD_DATA_IN,
    input  commandDone, busy, timeoutError,
    input  LCD_E, LCD_RS, LCD_RW, LCD_DATA_OUT, LCD_DATA_OE
  );

  modport slave (
    input  sendCommand, command, commandRs, readBusy, LCD_DATA_IN,
    output commandDone, busy, timeoutError,
    output LCD_E, LCD_RS, LCD_RW, LCD_DATA_OUT, LCD_DATA_OE
  );

endinterface

// File: rtl/lcd_bus_phase_timer.sv
// rtl/lcd_bus_phase_timer.sv - down-counter timing the SETUP/EHI/HOLD/GAP phases of one E pulse
module lcd_bus_phase_timer
  import lcd_pkg::*;
#(
  parameter int T_AS = T_AS_DEFAULT,
  parameter int T_PW = T_PW_DEFAULT,
  parameter int T_H  = T_H_DEFAULT,
  parameter int T_EL = T_EL_DEFAULT
) (
  input  logic   CLK,
  input  logic   RESET,
  input  logic   load_i,
  input  phase_t phase_i,
  output logic   phase_end_o
);

  localparam int MAX_AB = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int MAX_CD = (T_H > T_EL) ? T_H : T_EL;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_T + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] load_val;

  // Loaded with length-1 so phase_end marks the final cycle of the phase
  always_comb begin
    load_val = CW'(T_AS - 1);
    case (phase_i)
      PH_SETUP: load_val = CW'(T_AS - 1);
      PH_EHI:   load_val = CW'(T_PW - 1);
      PH_HOLD:  load_val = CW'(T_H - 1);
      PH_GAP:   load_val = CW'(T_EL - 1);
      default:  load_val = CW'(T_AS - 1);
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_bus_driver.sv
// rtl/lcd_nibble_bus_driver.sv - HD44780 4-bit bus cycle generator with busy-flag polling
module lcd_nibble_bus_driver
  import lcd_pkg::*;
#(
  parameter int T_AS       = T_AS_DEFAULT,
  parameter int T_PW       = T_PW_DEFAULT,
  parameter int T_H        = T_H_DEFAULT,
  parameter int T_EL       = T_EL_DEFAULT,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                   CLK,
  input  logic                   RESET,
  lcd_nibble_bus_driver_if.slave bus
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

  state_t        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          cmd_rs_q, cmd_rs_d;
  logic          rb_q, rb_d;
  logic          second_q, second_d;
  logic          bf_q, bf_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          to_q, to_d;
  logic          e_q, e_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          rw_q, rw_d;
  logic          oe_q, oe_d;
  logic [3:0]    dout_q, dout_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          phase_end;
  logic          timer_load;
  logic          in_write;

  lcd_bus_phase_timer #(
    .T_AS (T_AS),
    .T_PW (T_PW),
    .T_H  (T_H),
    .T_EL (T_EL)
  ) u_timer (
    .CLK         (CLK),
    .RESET       (RESET),
    .load_i      (timer_load),
    .phase_i     (phase_of(state_d)),
    .phase_end_o (phase_end)
  );

  assign timer_load = (state_d != state_q);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cmd_rs_d = cmd_rs_q;
    rb_d     = rb_q;
    second_d = second_q;
    bf_d     = bf_q;
    poll_d   = poll_q;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (bus.sendCommand) begin
          cmd_d    = bus.command;
          cmd_rs_d = bus.commandRs;
          rb_d     = bus.readBusy;
          poll_d   = '0;
          second_d = 1'b0;
          state_d  = W_SETUP;
        end
      end
      W_SETUP: if (phase_end) state_d = W_EHI;
      W_EHI:   if (phase_end) state_d = W_HOLD;
      W_HOLD:  if (phase_end) state_d = W_GAP;
      W_GAP:   if (phase_end) state_d = rb_q ? R_SETUP : DONE;
      R_SETUP: if (phase_end) state_d = R_EHI;
      R_EHI: begin
        if (phase_end) begin
          if (!second_q) bf_d = bus.LCD_DATA_IN[BF_BIT];
          state_d = R_HOLD;
        end
      end
      R_HOLD:  if (phase_end) state_d = R_GAP;
      R_GAP: begin
        if (phase_end) begin
          if (!second_q) begin
            second_d = 1'b1;
            state_d  = R_SETUP;
          end else begin
            second_d = 1'b0;
            if (!bf_q) begin
              state_d = DONE;
            end else if (poll_q < POLL_MAX) begin
              poll_d  = poll_q + 1'b1;
              state_d = R_SETUP;
            end else begin
              to_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values follow the next state so every pin comes straight from a flop
  always_comb begin
    in_write = (state_d == W_SETUP) || (state_d == W_EHI) ||
               (state_d == W_HOLD)  || (state_d == W_GAP);
    e_d      = (state_d == W_EHI) || (state_d == R_EHI);
    lcd_rs_d = in_write ? cmd_rs_d : 1'b0;
    oe_d     = in_write;
    // First R_SETUP cycle keeps RW low so OE has already dropped before RW rises
    rw_d     = (state_d == R_EHI) || (state_d == R_HOLD) || (state_d == R_GAP) ||
               ((state_d == R_SETUP) && (state_q == R_SETUP));
    dout_d   = in_write ? cmd_d : dout_q;
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      cmd_rs_q <= 1'b0;
      rb_q     <= 1'b0;
      second_q <= 1'b0;
      bf_q     <= 1'b0;
      poll_q   <= '0;
      to_q     <= 1'b0;
      e_q      <= 1'b0;
      lcd_rs_q <= 1'b0;
      rw_q     <= 1'b0;
      oe_q     <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmd_rs_q <= cmd_rs_d;
      rb_q     <= rb_d;
      second_q <= second_d;
      bf_q     <= bf_d;
      poll_q   <= poll_d;
      to_q     <= to_d;
      e_q      <= e_d;
      lcd_rs_q <= lcd_rs_d;
      rw_q     <= rw_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.LCD_E        = e_q;
  assign bus.LCD_RS       = lcd_rs_q;
  assign bus.LCD_RW       = rw_q;
  assign bus.LCD_DATA_OE  = oe_q;
  assign bus.LCD_DATA_OUT = dout_q;
  assign bus.commandDone  = done_q;
  assign bus.busy         = busy_q;
  assign bus.timeoutError = to_q;

endmodule

// File: tb/tb_lcd_nibble_bus_driver.sv
// tb/tb_lcd_nibble_bus_driver.sv - scoreboard bench for lcd_nibble_bus_driver with an LCD busy-flag model
module tb_lcd_nibble_bus_driver;
  import lcd_pkg::*;

  localparam int TAS   = 2;
  localparam int TPW   = 12;
  localparam int TH    = 2;
  localparam int TEL   = 13;
  localparam int PL    = 4;
  localparam int PULSE = TAS + TPW + TH + TEL;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  lcd_nibble_bus_driver_if bus();

  lcd_nibble_bus_driver #(
    .T_AS       (TAS),
    .T_PW       (TPW),
    .T_H        (TH),
    .T_EL       (TEL),
    .POLL_LIMIT (PL)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         lat;
    logic       to;
    int         pulses;
    logic [3:0] nib;
    logic       rs;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   busy_polls = 0;
  logic to_sticky = 1'b0;

  always @(posedge CLK) cyc++;

  logic       e_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic [6:0] bus_prev = '0;
  int         ewidth = 0;
  int         elow = 0;
  int         pulse_cnt = 0;
  int         read_cnt = 0;
  int         r1_cnt = 0;
  bit         had_pulse = 0;

  always @(negedge CLK) begin
    exp_t x;
    logic [6:0] bus_now;
    bus_now = {bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA_OE, bus.LCD_DATA_OUT};
    if (RESET) begin
      e_prev = 1'b0; done_prev = 1'b0; bus_prev = bus_now;
      ewidth = 0; elow = 0; pulse_cnt = 0; read_cnt = 0; r1_cnt = 0; had_pulse = 0;
      bus.LCD_DATA_IN = 4'h0;
    end else begin
      check_eq("rw_with_oe", {31'd0, bus.LCD_RW & bus.LCD_DATA_OE}, 32'd0);
      if (bus.LCD_E || e_prev) check_eq("bus_stable_near_e", {25'd0, bus_now}, {25'd0, bus_prev});
      if (bus.LCD_E && !e_prev) begin
        if (had_pulse) check_eq("e_low_gap", {31'd0, elow >= TH + TEL}, 32'd1);
        pulse_cnt++;
        ewidth = 1;
        if (bus.LCD_RW) begin
          check_eq("read_oe", {31'd0, bus.LCD_DATA_OE}, 32'd0);
          check_eq("read_rs", {31'd0, bus.LCD_RS}, 32'd0);
          if (read_cnt % 2 == 0) begin
            r1_cnt++;
            bus.LCD_DATA_IN = (r1_cnt <= busy_polls) ? 4'b1000 : 4'b0000;
          end
          read_cnt++;
        end else begin
          check_eq("write_oe", {31'd0, bus.LCD_DATA_OE}, 32'd1);
          if (sb.size() > 0) begin
            check_eq("write_data", {28'd0, bus.LCD_DATA_OUT}, {28'd0, sb[0].nib});
            check_eq("write_rs", {31'd0, bus.LCD_RS}, {31'd0, sb[0].rs});
          end
        end
      end else if (bus.LCD_E) begin
        ewidth++;
      end
      if (!bus.LCD_E && e_prev) begin
        check_eq("e_width", ewidth, TPW);
        had_pulse = 1;
        elow = 1;
      end else if (!bus.LCD_E) begin
        elow++;
      end
      if (done_prev) begin
        check_eq("done_single_cycle", {31'd0, bus.commandDone}, 32'd0);
        check_eq("busy_after_done", {31'd0, bus.busy}, 32'd0);
      end
      if (bus.commandDone) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 32'd1, 32'd0);
        end else begin
          x = sb.pop_front();
          check_eq("latency", cyc - x.acc, x.lat);
          check_eq("timeout_flag", {31'd0, bus.timeoutError}, {31'd0, x.to});
          check_eq("e_pulse_count", pulse_cnt, x.pulses);
          check_eq("busy_at_done", {31'd0, bus.busy}, 32'd1);
        end
        pulse_cnt = 0; read_cnt = 0; r1_cnt = 0;
      end
      e_prev    = bus.LCD_E;
      done_prev = bus.commandDone;
      bus_prev  = bus_now;
    end
  end

  task automatic send(input logic [3:0] nib, input logic rs, input logic rb, input int bp);
    exp_t x;
    int   np;
    busy_polls = bp;
    np = rb ? ((bp + 1 < PL + 1) ? bp + 1 : PL + 1) : 0;
    x.lat    = PULSE + 2 * PULSE * np;
    x.to     = to_sticky | (rb && (bp >= PL + 1));
    to_sticky = x.to;
    x.pulses = 1 + 2 * np;
    x.nib    = nib;
    x.rs     = rs;
    @(negedge CLK);
    bus.command     = nib;
    bus.commandRs   = rs;
    bus.readBusy    = rb;
    bus.sendCommand = 1'b1;
    x.acc = cyc + 1;
    sb.push_back(x);
    @(negedge CLK);
    bus.sendCommand = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() > 0) begin
      check_eq("drain_wait_expired", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_e"},    {31'd0, bus.LCD_E}, 32'd0);
    check_eq({tag, "_rs"},   {31'd0, bus.LCD_RS}, 32'd0);
    check_eq({tag, "_rw"},   {31'd0, bus.LCD_RW}, 32'd0);
    check_eq({tag, "_oe"},   {31'd0, bus.LCD_DATA_OE}, 32'd0);
    check_eq({tag, "_data"}, {28'd0, bus.LCD_DATA_OUT}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, bus.commandDone}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_to"},   {31'd0, bus.timeoutError}, 32'd0);
  endtask

  initial begin
    bus.sendCommand = 1'b0;
    bus.command     = 4'h0;
    bus.commandRs   = 1'b0;
    bus.readBusy    = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    send(4'hA, 1'b1, 1'b0, 0);
    wait_drain(2000);

    send(4'h5, 1'b0, 1'b1, 3);
    wait_drain(2000);

    send(4'hC, 1'b1, 1'b1, 100);
    wait_drain(2000);
    @(negedge CLK);
    check_eq("timeout_sticky", {31'd0, bus.timeoutError}, 32'd1);

    send(4'h3, 1'b1, 1'b0, 0);
    repeat (4) @(negedge CLK);
    bus.command = 4'hF; bus.sendCommand = 1'b1;
    @(negedge CLK);
    bus.sendCommand = 1'b0;
    repeat (14) @(negedge CLK);
    bus.sendCommand = 1'b1;
    @(negedge CLK);
    bus.sendCommand = 1'b0;
    wait_drain(2000);

    send(4'h9, 1'b0, 1'b0, 0);
    wait_drain(2000);

    send(4'h6, 1'b0, 1'b0, 0);
    repeat (4) @(negedge CLK);
    check_eq("e_high_before_reset", {31'd0, bus.LCD_E}, 32'd1);
    RESET = 1'b1;
    #1;
    check_reset_values("midreset");
    sb.delete();
    to_sticky = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    send(4'h7, 1'b1, 1'b1, 1);
    wait_drain(2000);
    repeat (5) @(negedge CLK);
    check_eq("final_idle_busy", {31'd0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_bus_driver.md
# lcd_nibble_bus_driver

Physical-layer driver for an HD44780-compatible character LCD in 4-bit mode. It sits directly downstream of the text/command sequencer and receives one nibble at a time with RS and a busy-poll request over a pulse handshake. It generates the timed RS/RW/E/DB[7:4] bus cycle and, when requested, polls the busy flag until the controller is ready. It then returns a one-cycle completion pulse.

## Interface
Parameters:
- T_AS, default 2: address/data setup cycles, RS/RW/DB valid before E rises.
- T_PW, default 12: E high width, in cycles.
- T_H, default 2: hold cycles after E falls, before RS/RW/DB may change.
- T_EL, default 13: minimum E low gap, in cycles, before the next bus cycle or completion.
- POLL_LIMIT, default 1024: maximum busy polls before timeout.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- sendCommand  in  1  one-cycle request pulse.
- command  in  4  nibble to write (DB7..DB4).
- commandRs  in  1  RS for the write.
- readBusy  in  1  poll busy flag after the write when 1.
- commandDone  out  1  one-cycle completion pulse.
- busy  out  1  high from acceptance until the commandDone cycle inclusive.
- LCD_E  out  1  enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  0 = write, 1 = read.
- LCD_DATA_OUT  out  4  DB7..DB4 drive value.
- LCD_DATA_OE  out  1  tri-state enable for DB7..DB4.
- LCD_DATA_IN  in  4  DB7..DB4 sampled value.
- timeoutError  out  1  sticky flag; set when POLL_LIMIT is exceeded.

## Operation
- All LCD_* outputs, commandDone, busy and timeoutError are registered; no combinational path to the pins.
- Reset values: LCD_E, LCD_RS, LCD_RW and LCD_DATA_OE are 0. LCD_DATA_OUT is 0. commandDone, busy and timeoutError are 0. The state is IDLE.
- Acceptance:
  - In IDLE, sendCommand=1 at a clock edge latches command, commandRs and readBusy.
  - sendCommand is ignored in every other state (no queueing).
- States: IDLE → W_SETUP → W_EHI → W_HOLD → W_GAP → (readBusy ? R_SETUP : DONE).
- Write phases:
  - W_SETUP lasts T_AS cycles: RS=latched RS, RW=0, OE=1, DATA_OUT=latched nibble, E=0.
  - W_EHI lasts T_PW cycles with E=1.
  - W_HOLD lasts T_H cycles with E=0 and bus unchanged.
  - W_GAP lasts T_EL cycles: E=0, OE=1, RS and DATA unchanged.
- Busy poll:
  - Each poll is two read pulses, R1 then R2, each with the phases SETUP(T_AS), EHI(T_PW), HOLD(T_H), GAP(T_EL).
  - Read bus state is RS=0, RW=1, OE=0.
  - BF = LCD_DATA_IN[3], sampled on the last cycle of R1 EHI. The R2 data is discarded.
  - After R2 GAP: if BF=0, go to DONE. If BF=1 and the poll count is below POLL_LIMIT, increment the count and repeat R1. Otherwise set timeoutError and go to DONE.
- DONE lasts one cycle with commandDone=1, then IDLE. The bus returns to idle values: RS=0, RW=0, OE=0, E=0.
- Bus rules:
  - RW, RS, OE and DATA_OUT change only while E=0 and never in the same cycle E changes.
  - OE=0 whenever RW=1.
  - The OE drop precedes RW=1 by at least one cycle: the first cycle of R_SETUP has OE=0, RW=0. RW=1 then applies for the remaining T_AS-1 cycles, so T_AS ≥ 2 is required.
- Widths:
  - Phase counter width is $clog2(max(T_AS,T_PW,T_H,T_EL)+1).
  - Poll counter width is $clog2(POLL_LIMIT+1).
- timeoutError clears only on RESET.
- Reset mid-operation: all outputs return to reset values asynchronously. No partial E pulse is continued.

## Timing
- Write without poll: commandDone is high in cycle T_AS+T_PW+T_H+T_EL after the acceptance edge. With default parameters that is 29.
- Each busy poll adds 2·(T_AS+T_PW+T_H+T_EL) cycles, 58 with defaults.
- E high is exactly T_PW consecutive cycles; there are no glitches.
- busy rises the cycle after acceptance and falls the cycle after commandDone.
- Back-to-back commands: a sendCommand sampled in the cycle after DONE is accepted.

## Structure
- Shared package lcd_pkg holds:
  - the state enum;
  - default timing constants T_AS, T_PW, T_H, T_EL;
  - the BF bit index.
- Sub-module lcd_bus_phase_timer: a down-counter that sequences SETUP/EHI/HOLD/GAP and reports phase_end. It is reused for the write pulse and both read pulses. The top level holds the FSM, latches and poll counter.

## Test plan
- Write, readBusy=0, command=4'hA, RS=1, default params: E high for exactly 12 cycles, DATA_OUT=4'hA, RS=1, RW=0, OE=1 throughout. commandDone is a single pulse 29 cycles after acceptance.
- Write with readBusy=1, model returns BF=1 for 3 polls then 0: 4 polls, i.e. 8 read E pulses. During reads RW=1 and OE=0. commandDone arrives at cycle 29+4·58=261.
- BF held 1, POLL_LIMIT=4: timeoutError is set, commandDone pulses once, and a later command still completes with timeoutError still 1.
- sendCommand pulsed again at cycles 5 and 20 during a write: ignored, exactly one E pulse, one commandDone.
- RESET asserted during W_EHI: E drops immediately and all outputs take reset values. After release, a new command completes normally.
- Bus checker over all tests:
  - no RS/RW/DATA/OE change while E=1 or in an E-edge cycle;
  - never RW=1 with OE=1;
  - E low ≥ T_H+T_EL between pulses.
